// File: rtl/residual_add_ctrl.sv
// residual_add_ctrl
// Residual-add sequencer for the shared FMA array. A start pulse launches an
// operation of n = min(n_tile_cfg, N_TILE) tiles. One tile of
// (sublayer output, residual input) is issued per cycle. An FMA_LAT-deep
// (valid, idx) shift register follows the array pipeline, so each result is
// captured with its tile index. A one-cycle done pulse marks completion.
//
// Build option: define RESIDUAL_SCALE_EN to add the scale port. The issue
// cycles then compute a*scale+c (FMA mode) instead of a+c (ADD mode).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, n_tile_cfg start pulse (ignored while busy) and tile count
//   src_idx           tile requested this cycle; src_a/src_c return it
//   mode_fma, a_fma, b_fma, c_fma   FMA array controls/operands
//   FMA_out           FMA array result, FMA_LAT cycles after issue
//   scale             residual scale (RESIDUAL_SCALE_EN builds only)
//   busy, done        operation status
//   res_out, res_out_idx, res_out_valid   captured result stream
module residual_add_ctrl #(
  parameter int BW_FP    = 17,
  parameter int VALUE_MN = 64,
  parameter int N_TILE   = 4,
  parameter int FMA_LAT  = 2,
  parameter int TW       = $clog2(N_TILE + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TW-1:0]             n_tile_cfg,
  output logic [TW-1:0]             src_idx,
  input  logic [VALUE_MN*BW_FP-1:0] src_a,
  input  logic [VALUE_MN*BW_FP-1:0] src_c,
  output logic [VALUE_MN*5-1:0]     mode_fma,
  output logic [VALUE_MN*BW_FP-1:0] a_fma,
  output logic [VALUE_MN*BW_FP-1:0] b_fma,
  output logic [VALUE_MN*BW_FP-1:0] c_fma,
  input  logic [VALUE_MN*BW_FP-1:0] FMA_out,
`ifdef RESIDUAL_SCALE_EN
  input  logic [BW_FP-1:0]          scale,
`endif
  output logic                      busy,
  output logic [VALUE_MN*BW_FP-1:0] res_out,
  output logic [TW-1:0]             res_out_idx,
  output logic                      res_out_valid,
  output logic                      done
);

  localparam logic [4:0] MODE_ADD = 5'b01000;
  localparam logic [4:0] MODE_FMA = 5'b00100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [TW-1:0]        n_r;
  logic [TW-1:0]        k_r;
  logic [TW-1:0]        n_clamp_s;
  logic                 start_ok_s;
  logic                 issue_s;
  logic                 done_s;
  logic [FMA_LAT-1:0]   pv_r;
  logic [TW-1:0]        pidx_r [FMA_LAT];
`ifdef RESIDUAL_SCALE_EN
  logic [BW_FP-1:0]     scale_r;
`endif

  // Tile-count clamp applied when start is accepted
  always_comb begin
    if (n_tile_cfg > TW'(N_TILE)) begin
      n_clamp_s = TW'(N_TILE);
    end else begin
      n_clamp_s = n_tile_cfg;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_s    = state_r;
    start_ok_s = 1'b0;
    issue_s    = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_ok_s = 1'b1;
          // n=0 goes straight to DRAIN: the pipeline is empty, so done fires next cycle
          state_s = (n_clamp_s == TW'(0)) ? DRAIN : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        issue_s = 1'b1;
        if (k_r == n_r - TW'(1)) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        // The last result is being presented while the pipeline reads empty
        if (pv_r == '0) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand and status outputs, all forced to zero outside ISSUE
  always_comb begin
    src_idx  = '0;
    a_fma    = '0;
    b_fma    = '0;
    c_fma    = '0;
    mode_fma = '0;
    if (issue_s) begin
      src_idx = k_r;
      a_fma   = src_a;
      c_fma   = src_c;
`ifdef RESIDUAL_SCALE_EN
      b_fma    = {VALUE_MN{scale_r}};
      mode_fma = {VALUE_MN{MODE_FMA}};
`else
      b_fma    = '0;
      mode_fma = {VALUE_MN{MODE_ADD}};
`endif
    end else begin
      src_idx = '0;
    end
    busy = (state_r != IDLE);
    done = done_s;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Tile count latch and issue counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_r <= '0;
      k_r <= '0;
    end else if (start_ok_s) begin
      n_r <= n_clamp_s;
      k_r <= '0;
    end else if (issue_s) begin
      k_r <= k_r + TW'(1);
    end else begin
      k_r <= k_r;
    end
  end

`ifdef RESIDUAL_SCALE_EN
  // Scale is held for the whole operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scale_r <= '0;
    end else if (start_ok_s) begin
      scale_r <= scale;
    end else begin
      scale_r <= scale_r;
    end
  end
`endif

  // (valid, idx) shadow of the FMA pipeline; the tail lines up with FMA_out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_r <= '0;
      for (int i = 0; i < FMA_LAT; i++) begin
        pidx_r[i] <= '0;
      end
    end else begin
      pv_r[0]   <= issue_s;
      pidx_r[0] <= k_r;
      for (int i = 1; i < FMA_LAT; i++) begin
        pv_r[i]   <= pv_r[i-1];
        pidx_r[i] <= pidx_r[i-1];
      end
    end
  end

  // Result capture; res_out holds its value between valid tiles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_out       <= '0;
      res_out_idx   <= '0;
      res_out_valid <= 1'b0;
    end else if (pv_r[FMA_LAT-1]) begin
      res_out       <= FMA_out;
      res_out_idx   <= pidx_r[FMA_LAT-1];
      res_out_valid <= 1'b1;
    end else begin
      res_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_residual_add_ctrl.sv
// Directed bench for residual_add_ctrl with a behavioural FMA array
// (lane-wise a+c, FMA_LAT cycles deep) and a scoreboard of expected results.
module tb_residual_add_ctrl;
  localparam int BW_FP    = 17;
  localparam int VALUE_MN = 64;
  localparam int N_TILE   = 4;
  localparam int FMA_LAT  = 2;
  localparam int TW       = $clog2(N_TILE + 1);
  localparam int W        = VALUE_MN * BW_FP;

  typedef struct {
    logic [TW-1:0] idx;
    logic [W-1:0]  data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [TW-1:0]   n_tile_cfg = '0;
  logic [TW-1:0]   src_idx;
  logic [W-1:0]    src_a, src_c;
  logic [VALUE_MN*5-1:0] mode_fma;
  logic [W-1:0]    a_fma, b_fma, c_fma, FMA_out;
  logic [BW_FP-1:0] scale = 17'h0FF80;
  logic            busy, res_out_valid, done;
  logic [W-1:0]    res_out;
  logic [TW-1:0]   res_out_idx;

  logic [BW_FP-1:0] base_a = '0;
  logic [BW_FP-1:0] base_c = '0;
  logic [W-1:0]     fq [FMA_LAT];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_exp = 0;
  int   lat_exp = 0;
  bit   active = 1'b0;
  exp_t q[$];

  residual_add_ctrl #(
    .BW_FP(BW_FP), .VALUE_MN(VALUE_MN), .N_TILE(N_TILE), .FMA_LAT(FMA_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_tile_cfg(n_tile_cfg),
    .src_idx(src_idx), .src_a(src_a), .src_c(src_c), .mode_fma(mode_fma),
    .a_fma(a_fma), .b_fma(b_fma), .c_fma(c_fma), .FMA_out(FMA_out),
`ifdef RESIDUAL_SCALE_EN
    .scale(scale),
`endif
    .busy(busy), .res_out(res_out), .res_out_idx(res_out_idx),
    .res_out_valid(res_out_valid), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lanes(input logic [BW_FP-1:0] v);
    return {VALUE_MN{v}};
  endfunction

  function automatic logic [BW_FP-1:0] a_val(input logic [TW-1:0] idx);
    return base_a + BW_FP'(idx);
  endfunction

  function automatic logic [BW_FP-1:0] c_val(input logic [TW-1:0] idx);
    return base_c + (BW_FP'(idx) << 4);
  endfunction

  function automatic logic [W-1:0] add_lanes(input logic [W-1:0] a, input logic [W-1:0] c);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < VALUE_MN; l++) begin
      r[l*BW_FP +: BW_FP] = a[l*BW_FP +: BW_FP] + c[l*BW_FP +: BW_FP];
    end
    return r;
  endfunction

  // Source memory answers the requested tile in the same cycle
  always_comb begin
    src_a = lanes(a_val(src_idx));
    src_c = lanes(c_val(src_idx));
  end

  // Behavioural FMA array
  always_ff @(posedge clk) begin
    fq[0] <= add_lanes(a_fma, c_fma);
    for (int i = 1; i < FMA_LAT; i++) begin
      fq[i] <= fq[i-1];
    end
  end
  assign FMA_out = fq[FMA_LAT-1];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Per-cycle comparison of every output against the expected schedule
  task automatic monitor();
    bit iss, bsy, dn, rv;
    logic [TW-1:0] ei;
    exp_t e;
    iss = active && cyc >= 1 && cyc <= n_exp;
    bsy = active && cyc >= 1 && cyc <= lat_exp;
    dn  = active && cyc == lat_exp;
    rv  = active && n_exp > 0 && cyc >= FMA_LAT + 2 && cyc <= lat_exp;
    ei  = iss ? TW'(cyc - 1) : '0;
    chk("src_idx", W'(src_idx), W'(ei));
    chk("a_fma", a_fma, iss ? lanes(a_val(ei)) : '0);
    chk("c_fma", c_fma, iss ? lanes(c_val(ei)) : '0);
`ifdef RESIDUAL_SCALE_EN
    chk("b_fma", b_fma, iss ? lanes(scale) : '0);
    chk("mode_fma", W'(mode_fma), iss ? W'({VALUE_MN{5'b00100}}) : '0);
`else
    chk("b_fma", b_fma, '0);
    chk("mode_fma", W'(mode_fma), iss ? W'({VALUE_MN{5'b01000}}) : '0);
`endif
    chk("busy", W'(busy), W'(bsy));
    chk("done", W'(done), W'(dn));
    chk("res_out_valid", W'(res_out_valid), W'(rv));
    if (res_out_valid) begin
      if (q.size() == 0) begin
        chk("res_unexpected", W'(1'b1), W'(1'b0));
      end else begin
        e = q.pop_front();
        chk("res_out_idx", W'(res_out_idx), W'(e.idx));
        chk("res_out", res_out, e.data);
      end
    end
    if (done) begin
      chk("results_left_at_done", W'(q.size()), W'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  // One operation; extra_at injects a start during that cycle, rst_at pulses reset
  task automatic run_op(input int cfg, input int extra_at, input int rst_at);
    exp_t e;
    n_exp   = (cfg > N_TILE) ? N_TILE : cfg;
    lat_exp = (n_exp == 0) ? 1 : n_exp + FMA_LAT + 1;
    for (int i = 0; i < n_exp; i++) begin
      e.idx  = TW'(i);
      e.data = lanes(a_val(TW'(i)) + c_val(TW'(i)));
      q.push_back(e);
    end
    n_tile_cfg = TW'(cfg);
    start  = 1'b1;
    cyc    = 0;
    active = 1'b1;
    tick();
    while (active && cyc < lat_exp) begin
      start = (cyc == extra_at);
      n_tile_cfg = TW'(3);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        q.delete();
        active = 1'b0;
      end
      tick();
      rst_n = 1'b1;
    end
    start  = 1'b0;
    if (active) begin
      active = 1'b0;
      tick();
    end else begin
      chk("res_out_after_rst", res_out, '0);
      chk("res_out_idx_after_rst", W'(res_out_idx), '0);
      for (int i = 0; i < 6; i++) begin
        tick();
      end
    end
    chk("queue_empty", W'(q.size()), W'(0));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("res_out_rst", res_out, '0);
    chk("res_out_idx_rst", W'(res_out_idx), '0);
    tick();

    // Basic path: 0x100 + 0x200 = 0x300, done 4 cycles after start
    base_a = 17'h00100;
    base_c = 17'h00200;
    run_op(1, -1, -1);

    // Full stream, launched in the cycle after the previous done
    base_a = 17'h00000;
    base_c = 17'h00200;
    run_op(4, -1, -1);

    // Zero tiles and clamped count
    run_op(0, -1, -1);
    base_a = 17'h1FFFE;
    base_c = 17'h00005;
    run_op(7, -1, -1);

    // Start on the 2nd ISSUE cycle is ignored
    base_a = 17'h00030;
    run_op(3, 2, -1);

    // Reset one cycle after tile 1 is issued, then a normal operation
    run_op(4, -1, 3);
    base_a = 17'h0ABCD;
    base_c = 17'h01234;
    run_op(2, -1, -1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/residual_add_ctrl.md
# residual_add_ctrl

Parametrised residual-add sequencer for the shared FMA array. On a start pulse it streams up to N_TILE vector tiles of (sublayer output, residual input) through the FMA array, one tile per cycle, and tracks the FMA_LAT-deep result pipeline. It captures each result with its tile index and signals completion. It serves both the attention and FFN residual paths, with the tile count selected per operation.

## Interface
- BW_FP, 17, width of one FP element
- VALUE_MN, 64, elements per tile (FMA lanes)
- N_TILE, 4, maximum tiles per operation
- FMA_LAT, 2, FMA array latency in cycles (≥1)
- TW, $clog2(N_TILE+1), width of tile count and index
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  single-cycle pulse; accepted only while busy=0
- n_tile_cfg  in  TW  tiles to process; sampled with start
- src_idx  out  TW  tile index being requested this cycle
- src_a  in  VALUE_MN*BW_FP  sublayer output for tile src_idx (same cycle)
- src_c  in  VALUE_MN*BW_FP  residual input for tile src_idx (same cycle)
- mode_fma  out  VALUE_MN*5  per-lane FMA mode
- a_fma, b_fma, c_fma  out  VALUE_MN*BW_FP  FMA operands
- FMA_out  in  VALUE_MN*BW_FP  FMA result
- scale  in  BW_FP  residual scale (present only with RESIDUAL_SCALE_EN)
- busy  out  1  operation in progress
- res_out  out  VALUE_MN*BW_FP  captured result
- res_out_idx  out  TW  tile index of res_out
- res_out_valid  out  1  res_out valid this cycle
- done  out  1  single-cycle pulse, operation complete

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: start=1 latches n = min(n_tile_cfg, N_TILE) and clears the issue counter k.
  - n=0: go to DRAIN with an empty pipeline, so done fires on the next cycle and no tile is issued.
  - n>0: go to ISSUE.
- ISSUE: src_idx=k; a_fma=src_a; c_fma=src_c; mode_fma=VALUE_MN copies of 5'b01000 (ADD); b_fma=0.
  - k increments every cycle.
  - After issuing tile n-1, go to DRAIN.
- DRAIN: wait until no issued tile remains in the pipeline, then pulse done and go to IDLE.
- Valid/index tracking uses an FMA_LAT-deep shift register of (valid, idx).
- Result capture: when the pipeline tail is valid, res_out<=FMA_out, res_out_idx<=tail idx, res_out_valid<=1. Otherwise res_out_valid<=0 and res_out holds its value.
- Outside ISSUE: a_fma, b_fma, c_fma, mode_fma and src_idx are all 0.
- busy=1 in ISSUE and DRAIN, including the cycle in which done=1.
- start while busy=1 is ignored and has no side effects.
- Reset values: FSM=IDLE; busy, done, res_out_valid, res_out, res_out_idx, all pipeline valid bits and k are 0.
- Reset mid-operation: every in-flight tile is discarded, and no res_out_valid or done appears afterwards.

## Timing
- Start sampled at edge E0; the first ISSUE cycle follows E0.
- Tile k operands are driven in cycle I+k, where I is the first ISSUE cycle. FMA_out for tile k is valid in cycle I+k+FMA_LAT.
- res_out_valid for tile k is high in cycle I+k+FMA_LAT+1, with tile order preserved.
- res_out_valid cycles are back-to-back with no gaps.
- done is high in the same cycle as res_out_valid for tile n-1. busy falls on the following cycle.
- Total latency from start to done is n+FMA_LAT+1 cycles.
- Back-to-back operations: a start in the cycle after done is accepted.

## Configuration
- RESIDUAL_SCALE_EN defined:
  - scale port exists.
  - In ISSUE: b_fma = VALUE_MN copies of scale, and mode_fma = VALUE_MN copies of 5'b00100 (FMA, a*b+c).
  - scale is sampled with start and held for the whole operation.
- RESIDUAL_SCALE_EN undefined:
  - No scale port.
  - b_fma is always 0, and mode is ADD (5'b01000).
  - Timing is identical in both builds.

## Test plan
- Basic path: n_tile_cfg=1, FMA_LAT=2, model FMA_out=a+c with src_a lanes=17'h00100 and src_c lanes=17'h00200. Required: one res_out_valid with res_out lanes=17'h00300 and idx=0, done in the same cycle, 4 cycles after start.
- Full stream: n_tile_cfg=4, src_a=tile idx. Required: src_idx 0,1,2,3 on consecutive cycles; four contiguous res_out_valid with idx 0..3; done on idx 3; busy high for exactly 7 cycles.
- Edge counts: n_tile_cfg=0 gives a done pulse one cycle after start and no operand activity. n_tile_cfg=7 with N_TILE=4 is clamped to 4 tiles.
- Start while busy: a second start pulse on the 2nd ISSUE cycle is ignored, with no extra tiles and a single done. A start in the cycle after done launches a new operation.
- Reset mid-operation: rst_n=0 for 1 cycle after tile 1 is issued. Required: all outputs 0 on the following cycle and no later res_out_valid or done. A new start then behaves normally.
- RESIDUAL_SCALE_EN build: scale=17'h0FF80 and n=2. Required: b_fma lanes=scale and mode lanes=5'b00100 during ISSUE, and 0 outside ISSUE.
